// File: rtl/program_feeder.sv
// Feeds a stored program to a din/run/done processor one instruction at a time.
// Handles two-word immediate instructions and watches for a hung processor.
module program_feeder #(
    parameter int         DEPTH      = 16,
    parameter int         AW         = 4,
    parameter logic [2:0] IMM_OPCODE = 3'b001,
    parameter int         TIMEOUT    = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [15:0]   load_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    output logic [15:0]   proc_din,
    output logic          proc_run,
    input  logic          proc_done,
    output logic          busy,
    output logic          finished,
    output logic          timeout_err,
    output logic [AW-1:0] pc
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_FINISH = 3'd3;
    localparam logic [2:0] S_ERR    = 3'd4;

    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);

    logic [2:0]    state_q, state_d;
    logic [AW:0]   pc_q, pc_d;
    logic [AW:0]   len_q, len_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          finished_q, finished_d;
    logic          terr_q, terr_d;

    logic [15:0]   mem_q [DEPTH];
    logic [15:0]   cur_word;
    logic [AW:0]   pc_inc;
    logic          last_word;
    logic          mem_we;

    // pc is one bit wider internally so an immediate fetched past the last
    // word of a full-depth program still reads as "beyond the program".
    assign cur_word  = mem_q[pc_q[AW-1:0]];
    assign pc_inc    = pc_q + (AW+1)'(1);
    assign last_word = (pc_inc >= len_q);
    assign mem_we    = load_en && (state_q == S_IDLE);

    assign proc_din    = (state_q != S_IDLE && pc_q < len_q) ? cur_word : 16'h0000;
    assign proc_run    = (state_q == S_ISSUE);
    assign busy        = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_FINISH);
    assign finished    = finished_q;
    assign timeout_err = terr_q;
    assign pc          = pc_q[AW-1:0];

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[load_addr] <= load_data;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        len_d      = len_q;
        timer_d    = timer_q;
        finished_d = 1'b0;
        terr_d     = terr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (prog_len == '0) begin
                        finished_d = 1'b1;
                    end else begin
                        len_d   = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
                        pc_d    = '0;
                        terr_d  = 1'b0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                if (cur_word[8:6] == IMM_OPCODE) pc_d = pc_inc;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                // done wins over the watchdog when both land in the same cycle
                if (proc_done) begin
                    if (last_word) begin
                        finished_d = 1'b1;
                        state_d    = S_FINISH;
                    end else begin
                        pc_d    = pc_inc;
                        state_d = S_ISSUE;
                    end
                end else if (timer_q == T_LAST) begin
                    terr_d  = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_FINISH: state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            len_q      <= '0;
            timer_q    <= '0;
            finished_q <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            len_q      <= len_d;
            timer_q    <= timer_d;
            finished_q <= finished_d;
            terr_q     <= terr_d;
        end
    end

endmodule
